bk_wide_add_seq: RTL and testbench

- Multi-limb sequencer directly upstream and downstream of the 32-bit Brent-Kung adder.
- Accepts one wide add or subtract of WORDS×32 bits over a valid/ready handshake.
- Feeds the adder one 32-bit limb per cycle, least-significant limb first, and chains the adder's carry-out into the next limb's carry-in.
- Collects the sum limbs and returns the full result plus carry and signed overflow over a second valid/ready handshake.

---
 rtl/bk_wide_add_seq.sv | 118 +++++++++++
 tb/tb_bk_wide_add_seq.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/bk_wide_add_seq.sv
// bk_wide_add_seq: multi-limb add/subtract sequencer wrapped around
// an external 32-bit Brent-Kung adder, one limb per cycle, LSB first.
module bk_wide_add_seq #(
   parameter int WORDS = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [32*WORDS-1:0] in_a,
   input  logic [32*WORDS-1:0] in_b,
   input  logic                in_sub,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [32*WORDS-1:0] out_sum,
   output logic                out_co,
   output logic                out_ovf,
   output logic [31:0]         add_a,
   output logic [31:0]         add_b,
   output logic                add_ci,
   input  logic [31:0]         add_s,
   input  logic                add_co
);

   localparam int W  = 32 * WORDS;
   localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t          state;
   logic [IW-1:0]   idx;
   logic [W-1:0]    a_reg;
   logic [W-1:0]    b_reg;
   logic            sub_reg;
   logic            carry;
   logic            last;
   logic            run;

   assign run  = (state == RUN);
   assign last = (idx == LAST);

   // Present the current limb to the adder only while running;
   // subtraction is A + ~B + 1 with the +1 seeded into the carry.
   always_comb begin
      add_a  = '0;
      add_b  = '0;
      add_ci = 1'b0;
      if (run) begin
         add_a  = a_reg[32*idx +: 32];
         add_b  = b_reg[32*idx +: 32] ^ {32{sub_reg}};
         add_ci = carry;
      end
   end

   // Control FSM with registered handshake and result outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         idx       <= '0;
         a_reg     <= '0;
         b_reg     <= '0;
         sub_reg   <= 1'b0;
         carry     <= 1'b0;
         out_sum   <= '0;
         out_co    <= 1'b0;
         out_ovf   <= 1'b0;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  a_reg    <= in_a;
                  b_reg    <= in_b;
                  sub_reg  <= in_sub;
                  idx      <= '0;
                  carry    <= in_sub;
                  out_sum  <= '0;
                  in_ready <= 1'b0;
                  state    <= RUN;
               end
            end
            RUN: begin
               out_sum[32*idx +: 32] <= add_s;
               carry <= add_co;
               if (last) begin
                  idx       <= '0;
                  out_co    <= add_co;
                  out_ovf   <= (add_a[31] == add_b[31]) &&
                               (add_s[31] != add_a[31]);
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  idx <= idx + IW'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bk_wide_add_seq.sv
// tb_bk_wide_add_seq: scoreboard bench for the wide add sequencer,
// with a behavioural 32-bit adder standing in for the Brent-Kung unit.
module tb_bk_wide_add_seq;

   localparam int WORDS = 4;
   localparam int W     = 32 * WORDS;

   typedef struct packed {
      logic [W-1:0] sum;
      logic         co;
      logic         ovf;
   } res_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_a = '0;
   logic [W-1:0] in_b = '0;
   logic         in_sub = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] out_sum;
   logic         out_co;
   logic         out_ovf;
   logic [31:0]  add_a;
   logic [31:0]  add_b;
   logic         add_ci;
   logic [31:0]  add_s;
   logic         add_co;

   int   n_chk  = 0;
   int   n_pass = 0;
   res_t sb[$];

   bk_wide_add_seq #(.WORDS(WORDS)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_co(out_co), .out_ovf(out_ovf),
      .add_a(add_a), .add_b(add_b), .add_ci(add_ci),
      .add_s(add_s), .add_co(add_co)
   );

   assign {add_co, add_s} = {1'b0, add_a} + {1'b0, add_b} + {32'b0, add_ci};

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W-1:0] got,
                        input logic [W-1:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask

   function automatic res_t model(input logic [W-1:0] a,
                                  input logic [W-1:0] b,
                                  input logic sub);
      res_t r;
      logic [W-1:0] bb;
      logic [W:0]   full;
      bb    = sub ? ~b : b;
      full  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, sub};
      r.sum = full[W-1:0];
      r.co  = full[W];
      r.ovf = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
      return r;
   endfunction

   // Pop and compare whenever a result handshake is about to complete.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            check("sb_underflow", 1, 0);
         end else begin
            res_t e;
            e = sb.pop_front();
            check("sum", out_sum, e.sum);
            check("co", W'(out_co), W'(e.co));
            check("ovf", W'(out_ovf), W'(e.ovf));
         end
      end
   end

   task automatic start(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub);
      int n = 0;
      while (!in_ready && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!in_ready) check("start_timeout", 0, 1);
      in_a     = a;
      in_b     = b;
      in_sub   = sub;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      sb.push_back(model(a, b, sub));
   endtask

   task automatic wait_idle();
      int n = 0;
      while (!in_ready && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!in_ready) check("idle_timeout", 0, 1);
   endtask

   initial begin
      logic [3:0] exp_ci;
      res_t       hold;
      logic [W-1:0] ra, rb;

      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", W'(out_valid), 0);
      check("rst_ready", W'(in_ready), 1);
      check("rst_sum", out_sum, 0);
      check("rst_add", W'({add_a, add_b, add_ci}), 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // cross-limb carry, latency and per-limb carry-in
      exp_ci = 4'b1110;
      start(128'h00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'h1, 1'b0);
      for (int i = 0; i < WORDS; i++) begin
         check("limb_ci", W'(add_ci), W'(exp_ci[i]));
         check("early_valid", W'(out_valid), 0);
         @(posedge clk);
         #1;
      end
      check("lat_valid", W'(out_valid), 1);
      check("cross_sum", out_sum, 128'h00000001_00000000_00000000_00000000);
      wait_idle();

      start({W{1'b1}}, 128'h1, 1'b0);
      wait_idle();

      // borrow: limb 0 sees inverted B and carry-in 1
      start(128'h0, 128'h1, 1'b1);
      check("sub_b0", W'(add_b), W'(32'hFFFFFFFE));
      check("sub_ci0", W'(add_ci), 1);
      wait_idle();

      start(128'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'h1, 1'b0);
      wait_idle();
      start(128'h80000000_00000000_00000000_00000000, 128'h1, 1'b1);
      wait_idle();

      // backpressure while a new request is offered
      out_ready = 1'b0;
      hold = model(128'h1234, 128'h5678, 1'b0);
      start(128'h1234, 128'h5678, 1'b0);
      repeat (WORDS) @(posedge clk);
      #1;
      in_a     = 128'hDEAD;
      in_b     = 128'hBEEF;
      in_sub   = 1'b1;
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check("bp_valid", W'(out_valid), 1);
         check("bp_ready", W'(in_ready), 0);
         check("bp_sum", out_sum, hold.sum);
         @(posedge clk);
         #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_drop", W'(out_valid), 0);
      check("bp_idle", W'(in_ready), 1);
      start(128'h1_00000000, 128'hFFFFFFFF, 1'b0);
      wait_idle();

      // asynchronous reset between the second and third limb
      start({W{1'b1}}, {W{1'b1}}, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      sb.delete();
      check("mr_valid", W'(out_valid), 0);
      check("mr_sum", out_sum, 0);
      check("mr_add", W'({add_a, add_b, add_ci}), 0);
      check("mr_ready", W'(in_ready), 1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      start(128'd5, 128'd7, 1'b0);
      wait_idle();

      for (int k = 0; k < 6; k++) begin
         ra = {$urandom, $urandom, $urandom, $urandom};
         rb = {$urandom, $urandom, $urandom, $urandom};
         start(ra, rb, 1'($urandom_range(0, 1)));
         wait_idle();
      end

      repeat (2) @(posedge clk);
      check("sb_empty", W'(sb.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
